// File: rtl/pipe_ex_pkg.sv
// Shared constants, FSM encoding and the reference function for the
// four-operand pipeline F = ((A+B)+(C-D))*D.
package pipe_ex_pkg;

  localparam int PIPE_EX_N   = 10;
  localparam int PIPE_EX_LAT = 3;
  // Reference arithmetic is done at this width; callers truncate to N (N <= 32).
  localparam int REF_W       = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pipe_ex_state_e;

  // Add, subtract and multiply all commute with reduction mod 2^k, so
  // truncating this 32-bit result yields the exact N-bit pipeline answer.
  function automatic logic [REF_W-1:0] pipe_ex_ref(input logic [REF_W-1:0] a,
                                                    input logic [REF_W-1:0] b,
                                                    input logic [REF_W-1:0] c,
                                                    input logic [REF_W-1:0] d);
    return ((a + b) + (c - d)) * d;
  endfunction

endpackage

// File: rtl/pipe_ex_checker_if.sv
// Operand/result bus between the pipeline driver and the checker.
// in_valid qualifies A..D for exactly one cycle; there is no ready/backpressure.
// F carries no valid of its own: it is meaningful only on edges where an issued
// set reaches the end of the delay line.
interface pipe_ex_checker_if #(parameter int N = pipe_ex_pkg::PIPE_EX_N) ();
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] C;
  logic [N-1:0] D;
  logic         in_valid;
  logic [N-1:0] F;

  modport master (output A, B, C, D, in_valid, F);
  modport slave  (input  A, B, C, D, in_valid, F);
endinterface

// File: rtl/pipe_ex_dly.sv
// LAT-deep shift register of {valid, payload}; valid bits are async-reset and
// synchronously cleared, payload flops carry no reset.
module pipe_ex_dly #(
  parameter int W   = 40,
  parameter int LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         any_valid
);

  logic [LAT-1:0] vld_q, vld_d;
  logic [W-1:0]   data_q [LAT];
  logic [W-1:0]   data_d [LAT];

  always_comb begin
    vld_d     = '0;
    vld_d[0]  = in_valid & ~clr;
    data_d[0] = in_data;
    for (int k = 1; k < LAT; k++) begin
      vld_d[k]  = vld_q[k-1] & ~clr;
      data_d[k] = data_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < LAT; k++) data_q[k] <= data_d[k];
  end

  assign out_valid = vld_q[LAT-1];
  assign out_data  = data_q[LAT-1];
  assign any_valid = |vld_q;

endmodule

// File: rtl/pipe_ex_checker.sv
// Self-checking consumer for F = ((A+B)+(C-D))*D: delays issued operands by LAT,
// compares against F, keeps saturating pass/fail counts and a sticky err.
// Define PIPE_CHK_CAPTURE_EN to build the first-mismatch capture registers.
module pipe_ex_checker
  import pipe_ex_pkg::*;
#(
  parameter int N           = PIPE_EX_N,
  parameter int LAT         = PIPE_EX_LAT,
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  pipe_ex_checker_if.slave    bus,
  output logic [CNT_W-1:0]    pass_cnt,
  output logic [CNT_W-1:0]    fail_cnt,
  output logic                err,
  output logic                busy,
  output logic [N-1:0]        bad_exp,
  output logic [N-1:0]        bad_got,
  output pipe_ex_state_e      dbg_state
);

  localparam int W = 4 * N;

  logic         last_vld, any_vld;
  logic [W-1:0] last_data;
  logic [N-1:0] op_a, op_b, op_c, op_d, exp_val;
  logic         do_cmp, mismatch;

  pipe_ex_state_e state_q, state_d;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
  logic             err_q, err_d;

  pipe_ex_dly #(.W(W), .LAT(LAT)) u_dly (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (bus.in_valid),
    .in_data   ({bus.A, bus.B, bus.C, bus.D}),
    .out_valid (last_vld),
    .out_data  (last_data),
    .any_valid (any_vld)
  );

  assign {op_a, op_b, op_c, op_d} = last_data;
  assign exp_val  = N'(pipe_ex_ref(REF_W'(op_a), REF_W'(op_b), REF_W'(op_c), REF_W'(op_d)));
  // clr wins over a compare landing on the same edge.
  assign do_cmp   = last_vld && (state_q == RUN) && !clr;
  assign mismatch = do_cmp && (bus.F != exp_val);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN: begin
        if (mismatch && STOP_ON_ERR)          state_d = HALT;
        else if (!any_vld && !bus.in_valid)   state_d = IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    err_d  = err_q;
    if (clr) begin
      pass_d = '0;
      fail_d = '0;
      err_d  = 1'b0;
    end else if (do_cmp) begin
      if (mismatch) begin
        if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
        err_d = 1'b1;
      end else if (pass_q != '1) begin
        pass_d = pass_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pass_q  <= '0;
      fail_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

`ifdef PIPE_CHK_CAPTURE_EN
  logic [N-1:0] bad_exp_q, bad_exp_d, bad_got_q, bad_got_d;

  // err_q still low means this is the first mismatch since reset or clr.
  always_comb begin
    bad_exp_d = bad_exp_q;
    bad_got_d = bad_got_q;
    if (clr) begin
      bad_exp_d = '0;
      bad_got_d = '0;
    end else if (mismatch && !err_q) begin
      bad_exp_d = exp_val;
      bad_got_d = bus.F;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_exp_q <= '0;
      bad_got_q <= '0;
    end else begin
      bad_exp_q <= bad_exp_d;
      bad_got_q <= bad_got_d;
    end
  end

  assign bad_exp = bad_exp_q;
  assign bad_got = bad_got_q;
`else
  assign bad_exp = '0;
  assign bad_got = '0;
`endif

  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
  assign err       = err_q;
  assign busy      = any_vld | bus.in_valid;
  assign dbg_state = state_q;

endmodule
